// File: rtl/ms_io_uart.sv
`default_nettype none
//==============================================================================
//  Module   : ms_io_uart
//  Purpose  : IO-bus target holding an 8N1 UART. It has a TX FIFO, a
//             single-entry RX holding register and a programmable baud
//             divider. The bit period is BAUD+1 enabled clocks.
//  Ports    : AClkH/AResetH/AClkHEn     clock, sync active-high reset, enable
//             AIoAddr/AIoMosi           IO byte address, write data (right-aligned)
//             AIoWrSize/AIoRdSize       one-hot access sizes, 0 = no access
//             AIoMiso/AIoBusy           registered read data, combinational stall
//             ADataI/ADataO             serial RX (async) / TX lines, idle high
//             AIrq                      interrupt request
//  Config   : MS_UART_IRQ_EN - adds the CTRL register (offset 3) and drives
//             AIrq. Without it, CTRL reads 0 and AIrq is tied low.
//  Revision : 1.0  initial release
//==============================================================================
module ms_io_uart #(
   parameter logic [15:0] CIoBase  = 16'h0010,
   parameter int          CTxDepth = 4,
   parameter logic [15:0] CBaudRst = 16'd15
) (
   input  logic        AClkH,
   input  logic        AResetH,
   input  logic        AClkHEn,
   input  logic [15:0] AIoAddr,
   input  logic [63:0] AIoMosi,
   input  logic [3:0]  AIoWrSize,
   input  logic [3:0]  AIoRdSize,
   output logic [63:0] AIoMiso,
   output logic        AIoBusy,
   input  logic        ADataI,
   output logic        ADataO,
   output logic        AIrq
);
   localparam int              c_ptrW  = (CTxDepth > 1) ? $clog2(CTxDepth) : 1;
   localparam logic [c_ptrW:0] c_depth = (c_ptrW+1)'(CTxDepth);

   typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3} txState_t;
   typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rxState_t;

   // ---------------- bus decode ----------------
   logic       w_hit, w_wrAny, w_rdAny;
   logic       w_wrData, w_wrBaud, w_wrCtrl, w_rdData, w_rdStat;
   logic [1:0] w_offset;

   assign w_hit    = (AIoAddr[15:2] == CIoBase[15:2]);
   assign w_offset = AIoAddr[1:0];
   assign w_wrAny  = w_hit & (AIoWrSize != 4'd0);
   // A simultaneous write wins; the read half of the request is dropped.
   assign w_rdAny  = w_hit & (AIoRdSize != 4'd0) & (AIoWrSize == 4'd0);
   assign w_wrData = w_wrAny & (w_offset == 2'd0);
   assign w_wrBaud = w_wrAny & (w_offset == 2'd2);
   assign w_wrCtrl = w_wrAny & (w_offset == 2'd3);
   assign w_rdData = AClkHEn & w_rdAny & (w_offset == 2'd0);
   assign w_rdStat = AClkHEn & w_rdAny & (w_offset == 2'd1);

   // ---------------- baud register ----------------
   logic [15:0] r_baud;
   always_ff @(posedge AClkH) begin
      if (AResetH) begin
         r_baud <= CBaudRst;
      end else if (AClkHEn && w_wrBaud) begin
         if (AIoWrSize == 4'd1) r_baud[7:0] <= AIoMosi[7:0];
         else                   r_baud      <= AIoMosi[15:0];
      end
   end

   // ---------------- TX FIFO ----------------
   logic [7:0]        r_txMem [CTxDepth];
   logic [c_ptrW-1:0] r_txWrPtr, r_txRdPtr;
   logic [c_ptrW:0]   r_txCount;
   logic              w_txEmpty, w_txFull, w_txPush, w_txPop, w_txLoad;

   assign w_txEmpty = (r_txCount == '0);
   assign w_txFull  = (r_txCount == c_depth);
   assign w_txPop   = AClkHEn & w_txLoad;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
   assign AIoBusy   = w_wrData & w_txFull & ~w_txPop;
   assign w_txPush  = AClkHEn & w_wrData & (~w_txFull | w_txPop);

   always_ff @(posedge AClkH) begin
      if (w_txPush) r_txMem[r_txWrPtr] <= AIoMosi[7:0];
   end

   always_ff @(posedge AClkH) begin
      if (AResetH) begin
         r_txWrPtr <= '0;
         r_txRdPtr <= '0;
         r_txCount <= '0;
      end else begin
         if (w_txPush) r_txWrPtr <= r_txWrPtr + 1'b1;
         if (w_txPop)  r_txRdPtr <= r_txRdPtr + 1'b1;
         if (w_txPush && !w_txPop)      r_txCount <= r_txCount + 1'b1;
         else if (!w_txPush && w_txPop) r_txCount <= r_txCount - 1'b1;
      end
   end

   // ---------------- TX shifter ----------------
   txState_t    r_txState, w_txNext;
   logic [15:0] r_txCnt;
   logic [2:0]  r_txBit;
   logic [7:0]  r_txShift;
   logic        w_txBitEnd, w_txIdle;

   assign w_txBitEnd = (r_txCnt == 16'd0);
   assign w_txIdle   = (r_txState == TX_IDLE);

   always_comb begin
      w_txNext = r_txState;
      w_txLoad = 1'b0;
      case (r_txState)
         TX_IDLE:  if (!w_txEmpty) begin
                      w_txNext = TX_START;
                      w_txLoad = 1'b1;
                   end
         TX_START: if (w_txBitEnd) w_txNext = TX_DATA;
         TX_DATA:  if (w_txBitEnd && (r_txBit == 3'd7)) w_txNext = TX_STOP;
         TX_STOP:  if (w_txBitEnd) begin
                      // Chain straight into the next start bit when data is waiting.
                      if (!w_txEmpty) begin
                         w_txNext = TX_START;
                         w_txLoad = 1'b1;
                      end else begin
                         w_txNext = TX_IDLE;
                      end
                   end
         default:  w_txNext = TX_IDLE;
      endcase
   end

   always_ff @(posedge AClkH) begin
      if (AResetH) begin
         r_txState <= TX_IDLE;
         r_txCnt   <= 16'd0;
         r_txBit   <= 3'd0;
         r_txShift <= 8'd0;
      end else if (AClkHEn) begin
         r_txState <= w_txNext;
         if (w_txLoad) begin
            r_txShift <= r_txMem[r_txRdPtr];
            r_txCnt   <= r_baud;
            r_txBit   <= 3'd0;
         end else if (!w_txIdle) begin
            if (w_txBitEnd) begin
               // Divider is resampled only here, so BAUD writes land on a bit boundary.
               r_txCnt <= r_baud;
               if (r_txState == TX_DATA) begin
                  r_txShift <= {1'b0, r_txShift[7:1]};
                  r_txBit   <= r_txBit + 3'd1;
               end
            end else begin
               r_txCnt <= r_txCnt - 16'd1;
            end
         end
      end
   end

   assign ADataO = (r_txState == TX_START) ? 1'b0 :
                   (r_txState == TX_DATA)  ? r_txShift[0] : 1'b1;

   // ---------------- RX path ----------------
   rxState_t    r_rxState, w_rxNext;
   logic [1:0]  r_rxSync;
   logic        r_rxPrev, w_rxIn, w_rxFall, w_rxSample, w_rxGood, w_rxFrame;
   logic [15:0] r_rxCnt, w_rxHalf;
   logic [2:0]  r_rxBit;
   logic [7:0]  r_rxShift, r_rxByte;
   logic        r_rxValid, r_rxOvf, r_rxFrErr;

   assign w_rxIn     = r_rxSync[1];
   assign w_rxFall   = r_rxPrev & ~w_rxIn;
   assign w_rxSample = (r_rxCnt == 16'd0);
   // (BAUD+1)>>1 without a 17-bit intermediate.
   assign w_rxHalf   = {1'b0, r_baud[15:1]} + {15'd0, r_baud[0]};
   assign w_rxGood   = AClkHEn & (r_rxState == RX_STOP) & w_rxSample & w_rxIn;
   assign w_rxFrame  = AClkHEn & (r_rxState == RX_STOP) & w_rxSample & ~w_rxIn;

   always_comb begin
      w_rxNext = r_rxState;
      case (r_rxState)
         RX_IDLE:  if (w_rxFall) w_rxNext = RX_START;
         RX_START: if (w_rxSample) w_rxNext = w_rxIn ? RX_IDLE : RX_DATA;  // high again = glitch
         RX_DATA:  if (w_rxSample && (r_rxBit == 3'd7)) w_rxNext = RX_STOP;
         RX_STOP:  if (w_rxSample) w_rxNext = RX_IDLE;
         default:  w_rxNext = RX_IDLE;
      endcase
   end

   always_ff @(posedge AClkH) begin
      if (AResetH) begin
         r_rxSync  <= 2'b11;
         r_rxPrev  <= 1'b1;
         r_rxState <= RX_IDLE;
         r_rxCnt   <= 16'd0;
         r_rxBit   <= 3'd0;
         r_rxShift <= 8'd0;
      end else if (AClkHEn) begin
         r_rxSync  <= {r_rxSync[0], ADataI};
         r_rxPrev  <= w_rxIn;
         r_rxState <= w_rxNext;
         if (r_rxState == RX_IDLE) begin
            r_rxBit <= 3'd0;
            if (w_rxFall) r_rxCnt <= (w_rxHalf == 16'd0) ? 16'd0 : w_rxHalf - 16'd1;
         end else if (w_rxSample) begin
            r_rxCnt <= r_baud;
            if (r_rxState == RX_DATA) begin
               r_rxShift <= {w_rxIn, r_rxShift[7:1]};
               r_rxBit   <= r_rxBit + 3'd1;
            end
         end else begin
            r_rxCnt <= r_rxCnt - 16'd1;
         end
      end
   end

   // A byte landing together with a DATA read is not an overflow: the read
   // consumes the old byte while the new one becomes valid.
   always_ff @(posedge AClkH) begin
      if (AResetH) begin
         r_rxByte   <= 8'd0;
         r_rxValid  <= 1'b0;
         r_rxOvf    <= 1'b0;
         r_rxFrErr  <= 1'b0;
      end else begin
         if (w_rxGood)      r_rxByte  <= r_rxShift;
         if (w_rxGood)      r_rxValid <= 1'b1;
         else if (w_rxData_clr(w_rdData)) r_rxValid <= 1'b0;
         if (w_rxGood && r_rxValid && !w_rdData) r_rxOvf <= 1'b1;
         else if (w_rdStat)                      r_rxOvf <= 1'b0;
         if (w_rxFrame)     r_rxFrErr <= 1'b1;
         else if (w_rdStat) r_rxFrErr <= 1'b0;
      end
   end

   function automatic logic w_rxData_clr(input logic rd);
      return rd;
   endfunction

   // ---------------- control / interrupt ----------------
   logic [15:0] w_ctrlRd;
`ifdef MS_UART_IRQ_EN
   logic [1:0] r_ctrl;
   logic       r_irq;
   always_ff @(posedge AClkH) begin
      if (AResetH) begin
         r_ctrl <= 2'b00;
         r_irq  <= 1'b0;
      end else if (AClkHEn) begin
         if (w_wrCtrl) r_ctrl <= AIoMosi[1:0];
         r_irq <= (r_rxValid & r_ctrl[0]) | (w_txEmpty & w_txIdle & r_ctrl[1]);
      end
   end
   assign w_ctrlRd = {14'd0, r_ctrl};
   assign AIrq     = r_irq;
   logic w_unused;
   assign w_unused = &{1'b0, AIoMosi[63:16]};
`else
   assign w_ctrlRd = 16'd0;
   assign AIrq     = 1'b0;
   logic w_unused;
   assign w_unused = &{1'b0, AIoMosi[63:16], w_wrCtrl};
`endif

   // ---------------- read data ----------------
   logic [15:0] w_rdVal;
   logic [63:0] r_miso;

   always_comb begin
      w_rdVal = 16'd0;
      case (w_offset)
         2'd0:    w_rdVal = {8'd0, r_rxByte};
         2'd1:    w_rdVal = {10'd0, r_rxFrErr, r_rxOvf, r_rxValid, w_txFull, w_txEmpty, w_txIdle};
         2'd2:    w_rdVal = r_baud;
         default: w_rdVal = w_ctrlRd;
      endcase
   end

   always_ff @(posedge AClkH) begin
      if (AResetH)      r_miso <= 64'd0;
      else if (AClkHEn) r_miso <= w_rdAny ? {48'd0, w_rdVal} : 64'd0;
   end

   assign AIoMiso = r_miso;

endmodule
`default_nettype wire
